// File: rtl/trng_pkg.sv
// Shared constants for the TRNG raw-bit health monitor: FSM state codes and
// default test cutoffs/window.
package trng_pkg;

   localparam logic [1:0] ST_BYPASS  = 2'b00;
   localparam logic [1:0] ST_STARTUP = 2'b01;
   localparam logic [1:0] ST_RUN     = 2'b10;
   localparam logic [1:0] ST_FAIL    = 2'b11;

   localparam int RCT_CUTOFF_DEF = 8;
   localparam int APT_WINDOW_DEF = 64;
   localparam int APT_CUTOFF_DEF = 48;

endpackage

// File: rtl/apt_window.sv
// Adaptive-proportion test: tracks the reference bit of the current window and
// how many valid bits matched it; fail_o flags the bit whose match hits CUTOFF.
module apt_window #(
   parameter int WINDOW = 64,
   parameter int CUTOFF = 48
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic valid_i,
   input  logic bit_i,
   output logic fail_o
);

   localparam int W = $clog2(WINDOW + 1);

   logic [W-1:0] win_cnt_q, win_cnt_d;
   logic [W-1:0] match_q, match_d;
   logic         ref_q, ref_d;

   // Window bookkeeping; a full window (count == WINDOW) is reopened by the next valid bit
   always_comb begin
      win_cnt_d = win_cnt_q;
      match_d   = match_q;
      ref_d     = ref_q;
      if (clr_i) begin
         win_cnt_d = '0;
         match_d   = '0;
         ref_d     = 1'b0;
      end else if (valid_i) begin
         if (win_cnt_q == '0 || win_cnt_q == W'(WINDOW)) begin
            ref_d     = bit_i;
            match_d   = W'(1);
            win_cnt_d = W'(1);
         end else begin
            win_cnt_d = win_cnt_q + W'(1);
            if (bit_i == ref_q && match_q < W'(CUTOFF)) begin
               match_d = match_q + W'(1);
            end else begin
               match_d = match_q;
            end
         end
      end else begin
         win_cnt_d = win_cnt_q;
      end
   end

   assign fail_o = valid_i && !clr_i && (match_d >= W'(CUTOFF));

   // Window state registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         win_cnt_q <= '0;
         match_q   <= '0;
         ref_q     <= 1'b0;
      end else begin
         win_cnt_q <= win_cnt_d;
         match_q   <= match_d;
         ref_q     <= ref_d;
      end
   end

endmodule

// File: rtl/entropy_health_monitor.sv
// Online health monitor for a raw oscillator bit stream (repetition count test,
// plus the adaptive-proportion test when HEALTH_APT_EN is defined).
module entropy_health_monitor
   import trng_pkg::*;
#(
   parameter int RCT_CUTOFF = RCT_CUTOFF_DEF,
   parameter int APT_WINDOW = APT_WINDOW_DEF,
   parameter int APT_CUTOFF = APT_CUTOFF_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bist_en,
   input  logic       in_valid,
   input  logic       in_bit,
   output logic       out_valid,
   output logic       out_bit,
   output logic       alarm,
   output logic [1:0] state
);

   localparam int RW = $clog2(RCT_CUTOFF + 1);
   localparam int SW = $clog2(APT_WINDOW + 1);

   logic [1:0]    state_q, state_d;
   logic          out_valid_q, out_valid_d;
   logic          out_bit_q, out_bit_d;
   logic          alarm_q, alarm_d;
   logic [RW-1:0] run_cnt_q, run_cnt_d;
   logic          prev_bit_q, prev_bit_d;
   logic [SW-1:0] start_cnt_q, start_cnt_d;

   logic          testing_s;
   logic          clr_s;
   logic [RW-1:0] run_next_s;
   logic          rct_fail_s;
   logic          apt_fail_s;
   logic          fail_s;

   assign testing_s = bist_en && in_valid && (state_q == ST_STARTUP || state_q == ST_RUN);
   assign clr_s     = !bist_en || (state_q == ST_BYPASS);

   // Repetition count: a zero count means no previous bit since the last clear
   always_comb begin
      run_next_s = run_cnt_q;
      if (run_cnt_q == '0 || in_bit != prev_bit_q) begin
         run_next_s = RW'(1);
      end else if (run_cnt_q < RW'(RCT_CUTOFF)) begin
         run_next_s = run_cnt_q + RW'(1);
      end else begin
         run_next_s = run_cnt_q;
      end
   end

   assign rct_fail_s = testing_s && (run_next_s >= RW'(RCT_CUTOFF));

`ifdef HEALTH_APT_EN
   apt_window #(
      .WINDOW(APT_WINDOW),
      .CUTOFF(APT_CUTOFF)
   ) u_apt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (clr_s),
      .valid_i(testing_s),
      .bit_i  (in_bit),
      .fail_o (apt_fail_s)
   );
`else
   assign apt_fail_s = 1'b0;
`endif

   assign fail_s = rct_fail_s || apt_fail_s;

   // Test counters and startup length counter
   always_comb begin
      run_cnt_d   = run_cnt_q;
      prev_bit_d  = prev_bit_q;
      start_cnt_d = start_cnt_q;
      if (clr_s) begin
         run_cnt_d   = '0;
         prev_bit_d  = 1'b0;
         start_cnt_d = '0;
      end else if (testing_s) begin
         run_cnt_d  = run_next_s;
         prev_bit_d = in_bit;
         if (state_q == ST_STARTUP) begin
            start_cnt_d = start_cnt_q + SW'(1);
         end else begin
            start_cnt_d = start_cnt_q;
         end
      end else begin
         run_cnt_d = run_cnt_q;
      end
   end

   // FSM and output next-state; a failing bit is never forwarded
   always_comb begin
      state_d     = state_q;
      out_valid_d = 1'b0;
      out_bit_d   = out_bit_q;
      alarm_d     = alarm_q;
      case (state_q)
         ST_BYPASS: begin
            out_valid_d = in_valid;
            out_bit_d   = in_bit;
            state_d     = bist_en ? ST_STARTUP : ST_BYPASS;
         end
         ST_STARTUP, ST_RUN: begin
            if (!bist_en) begin
               state_d = ST_BYPASS;
            end else if (fail_s) begin
               state_d = ST_FAIL;
               alarm_d = 1'b1;
            end else if (testing_s && state_q == ST_RUN) begin
               out_valid_d = 1'b1;
               out_bit_d   = in_bit;
            end else if (testing_s && start_cnt_q == SW'(APT_WINDOW - 1)) begin
               state_d = ST_RUN;
            end else begin
               state_d = state_q;
            end
         end
         ST_FAIL: begin
            state_d = bist_en ? ST_FAIL : ST_BYPASS;
         end
         default: begin
            state_d = ST_BYPASS;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_BYPASS;
         out_valid_q <= 1'b0;
         out_bit_q   <= 1'b0;
         alarm_q     <= 1'b0;
         run_cnt_q   <= '0;
         prev_bit_q  <= 1'b0;
         start_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_bit_q   <= out_bit_d;
         alarm_q     <= alarm_d;
         run_cnt_q   <= run_cnt_d;
         prev_bit_q  <= prev_bit_d;
         start_cnt_q <= start_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_bit   = out_bit_q;
   assign alarm     = alarm_q;
   assign state     = state_q;

endmodule

// File: tb/tb_entropy_health_monitor.sv
// Directed self-checking bench for entropy_health_monitor (default parameters;
// APT expectations follow HEALTH_APT_EN).
module tb_entropy_health_monitor;

   logic       clk;
   logic       rst_n;
   logic       bist_en;
   logic       in_valid;
   logic       in_bit;
   logic       out_valid;
   logic       out_bit;
   logic       alarm;
   logic [1:0] state;

   int n_tests = 0;
   int n_fail  = 0;

   entropy_health_monitor dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bist_en  (bist_en),
      .in_valid (in_valid),
      .in_bit   (in_bit),
      .out_valid(out_valid),
      .out_bit  (out_bit),
      .alarm    (alarm),
      .state    (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic b);
      in_valid = v;
      in_bit   = b;
      @(posedge clk);
      #1;
   endtask

   // 64 alternating valid bits (0 first) with one idle cycle inserted
   task automatic run_startup();
      for (int i = 0; i < 64; i++) begin
         step(1'b1, i[0]);
         check("startup_no_fwd", {31'd0, out_valid}, 32'd0);
         if (i == 20) begin
            step(1'b0, 1'b1);
            check("startup_idle_state", {30'd0, state}, 32'd1);
         end
         check("startup_state", {30'd0, state}, (i == 63) ? 32'd2 : 32'd1);
      end
   endtask

   initial begin
      int zeros;
      rst_n    = 1'b0;
      bist_en  = 1'b0;
      in_valid = 1'b0;
      in_bit   = 1'b0;
      step(1'b0, 1'b0);
      step(1'b1, 1'b1);
      rst_n = 1'b1;
      check("reset_state", {30'd0, state}, 32'd0);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_out_bit", {31'd0, out_bit}, 32'd0);
      check("reset_alarm", {31'd0, alarm}, 32'd0);

      // Bypass: one-cycle pass-through
      step(1'b1, 1'b0);
      check("byp_ov0", {31'd0, out_valid}, 32'd1);
      check("byp_ob0", {31'd0, out_bit}, 32'd0);
      step(1'b1, 1'b1);
      check("byp_ob1", {31'd0, out_bit}, 32'd1);
      step(1'b1, 1'b0);
      check("byp_ob2", {31'd0, out_bit}, 32'd0);
      step(1'b1, 1'b1);
      check("byp_ob3", {31'd0, out_bit}, 32'd1);
      check("byp_state", {30'd0, state}, 32'd0);
      step(1'b0, 1'b1);
      check("byp_ov_idle", {31'd0, out_valid}, 32'd0);

      // Startup then run
      bist_en = 1'b1;
      step(1'b0, 1'b0);
      check("enter_startup", {30'd0, state}, 32'd1);
      run_startup();
      step(1'b1, 1'b0);
      check("run_bit65_ov", {31'd0, out_valid}, 32'd1);
      check("run_bit65_ob", {31'd0, out_bit}, 32'd0);
      step(1'b0, 1'b1);
      check("run_idle_ov", {31'd0, out_valid}, 32'd0);

      // RCT: eight consecutive ones, the eighth fails
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 1'b1);
         if (k < 8) begin
            check("rct_fwd_ov", {31'd0, out_valid}, 32'd1);
            check("rct_fwd_ob", {31'd0, out_bit}, 32'd1);
            check("rct_run_state", {30'd0, state}, 32'd2);
         end else begin
            check("rct_fail_ov", {31'd0, out_valid}, 32'd0);
            check("rct_fail_state", {30'd0, state}, 32'd3);
            check("rct_fail_alarm", {31'd0, alarm}, 32'd1);
         end
      end
      step(1'b1, 1'b0);
      check("fail_hold_ov", {31'd0, out_valid}, 32'd0);
      check("fail_hold_state", {30'd0, state}, 32'd3);

      // Leaving FAIL through bypass keeps alarm; reset clears it
      bist_en = 1'b0;
      step(1'b0, 1'b0);
      check("fail_to_byp_state", {30'd0, state}, 32'd0);
      check("fail_to_byp_alarm", {31'd0, alarm}, 32'd1);
      step(1'b1, 1'b1);
      check("byp_after_fail_ov", {31'd0, out_valid}, 32'd1);
      check("byp_after_fail_ob", {31'd0, out_bit}, 32'd1);
      rst_n = 1'b0;
      step(1'b0, 1'b0);
      rst_n = 1'b1;
      check("rst_alarm", {31'd0, alarm}, 32'd0);
      check("rst_state", {30'd0, state}, 32'd0);
      check("rst_ov", {31'd0, out_valid}, 32'd0);

      // APT: 48 zeros in runs of six, single ones between
      bist_en = 1'b1;
      step(1'b0, 1'b0);
      run_startup();
      zeros = 0;
      for (int g = 0; g < 8; g++) begin
         for (int z = 0; z < 6; z++) begin
            step(1'b1, 1'b0);
            zeros++;
`ifdef HEALTH_APT_EN
            if (zeros == 48) begin
               check("apt_fail_ov", {31'd0, out_valid}, 32'd0);
               check("apt_fail_state", {30'd0, state}, 32'd3);
               check("apt_fail_alarm", {31'd0, alarm}, 32'd1);
            end else begin
               check("apt_zero_ov", {31'd0, out_valid}, 32'd1);
               check("apt_zero_ob", {31'd0, out_bit}, 32'd0);
            end
`else
            check("apt_zero_ov", {31'd0, out_valid}, 32'd1);
            check("apt_zero_ob", {31'd0, out_bit}, 32'd0);
            check("apt_zero_state", {30'd0, state}, 32'd2);
`endif
         end
         if (g < 7) begin
            step(1'b1, 1'b1);
            check("apt_one_ov", {31'd0, out_valid}, 32'd1);
            check("apt_one_ob", {31'd0, out_bit}, 32'd1);
         end
      end
`ifdef HEALTH_APT_EN
      check("apt_end_state", {30'd0, state}, 32'd3);
`else
      check("apt_end_state", {30'd0, state}, 32'd2);
      check("apt_end_alarm", {31'd0, alarm}, 32'd0);
`endif

      // Reset mid-startup restarts the full startup count
      rst_n = 1'b0;
      step(1'b0, 1'b0);
      rst_n = 1'b1;
      step(1'b0, 1'b0);
      check("re_startup_state", {30'd0, state}, 32'd1);
      for (int i = 0; i < 30; i++) begin
         step(1'b1, i[0]);
      end
      check("mid_startup_state", {30'd0, state}, 32'd1);
      rst_n = 1'b0;
      step(1'b1, 1'b0);
      rst_n = 1'b1;
      check("mid_rst_state", {30'd0, state}, 32'd0);
      check("mid_rst_alarm", {31'd0, alarm}, 32'd0);
      step(1'b0, 1'b0);
      check("post_rst_startup", {30'd0, state}, 32'd1);
      run_startup();
      step(1'b1, 1'b0);
      check("post_rst_fwd_ov", {31'd0, out_valid}, 32'd1);
      check("post_rst_fwd_ob", {31'd0, out_bit}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/entropy_health_monitor.md
ENTROPY_HEALTH_MONITOR -- requirements
Module: entropy_health_monitor

Interface
REQ-001 SHALL have parameter RCT_CUTOFF, default 8, identical-bit run length that declares failure.
REQ-002 SHALL have parameter APT_WINDOW, default 64, adaptive-proportion window length in valid bits (power of two).
REQ-003 SHALL have parameter APT_CUTOFF, default 48, match count within one window that declares failure.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port bist_en  input  1  1 = health testing active; 0 = bypass.
REQ-007 SHALL have port in_valid  input  1  raw oscillator bit strobe.
REQ-008 SHALL have port in_bit  input  1  raw oscillator bit.
REQ-009 SHALL have port out_valid  output  1  forwarded-bit strobe to the Von Neumann unbiaser.
REQ-010 SHALL have port out_bit  output  1  forwarded bit.
REQ-011 SHALL have port alarm  output  1  sticky health-test failure flag.
REQ-012 SHALL have port state  output  2  current FSM state code.

Function
REQ-013 SHALL implement FSM: BYPASS=00, STARTUP=01, RUN=10, FAIL=11.
REQ-014 BYPASS: out_valid/out_bit SHALL equal in_valid/in_bit delayed exactly one cycle; counters held cleared; bist_en=1 -> STARTUP next cycle.
REQ-015 STARTUP: tests run on every valid bit, out_valid SHALL stay 0; after APT_WINDOW valid bits with no failure -> RUN.
REQ-016 RUN: each valid bit passing both tests SHALL be forwarded with one-cycle latency.
REQ-017 RCT: run counter SHALL reset to 1 on a bit differing from the previous valid bit, else increment (saturating at RCT_CUTOFF); reaching RCT_CUTOFF SHALL flag failure.
REQ-018 APT: first valid bit of a window SHALL become the reference (match count 1); each later matching bit increments; count reaching APT_CUTOFF SHALL flag failure; after APT_WINDOW bits the next valid bit opens a new window.
REQ-019 Failure in STARTUP or RUN SHALL move to FAIL next cycle, set alarm, and the failing bit SHALL NOT be forwarded.
REQ-020 FAIL: out_valid SHALL stay 0; alarm stays 1; exit only via rst_n or bist_en=0.
REQ-021 bist_en=0 in any state SHALL enter BYPASS next cycle and clear counters; alarm SHALL remain set (cleared only by reset).
REQ-022 Simultaneous RCT and APT failure on one bit SHALL be a single failure event; in_valid=0 cycles SHALL not change any counter.
REQ-023 Counter widths SHALL be clog2-sized from parameters; no wrap-around permitted.

Reset
REQ-024 rst_n=0 at a clock edge SHALL set state=BYPASS, out_valid=0, out_bit=0, alarm=0, all counters and reference bit cleared, including mid-window.

Configuration
REQ-025 With HEALTH_APT_EN defined, the APT (REQ-018) SHALL be compiled in; without it, APT logic is absent, only RCT can fail, and STARTUP still lasts APT_WINDOW valid bits.

Structure
REQ-026 State encodings and default cutoff/window constants SHALL live in shared package trng_pkg.
REQ-027 APT window/match logic SHALL be a sub-module apt_window, instantiated only under HEALTH_APT_EN.

Verification
REQ-028 bist_en=0, in alternating 0101 with in_valid=1 -> out identical one cycle later, state=00.
REQ-029 bist_en=1, alternating bits for 64 valid bits -> state=01 then 10; bit 65 forwarded one cycle later.
REQ-030 RUN, 8 consecutive 1s -> state=11, alarm=1, 8th bit not forwarded, out_valid stays 0.
REQ-031 HEALTH_APT_EN, RUN, window of 48 zeros among 64 bits with runs <=7 -> FAIL on 48th match; without macro -> stays RUN.
REQ-032 FAIL then bist_en=0 -> BYPASS, alarm=1; then rst_n=0 one cycle -> alarm=0, state=00.
REQ-033 rst_n=0 mid-STARTUP after 30 bits -> after release, bist_en=1 needs full 64 bits before RUN.
